// File: rtl/gs_pipeline_ctrl_if.sv
// Handshake bundle between the grayscale pass sequencer and its surroundings
// (top-level controller, RWM_1 source, Grayscaler, RWM_2 sink).
interface gs_pipeline_ctrl_if #(
  parameter int AW = 8
);
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic          gs_enable;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          pause;
  logic          gs_valid;
  logic          gs_done;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  modport master (
    input  start, rd_valid, pause, gs_valid, gs_done,
    output busy, done, err, gs_enable, rd_en, rd_addr, wr_en, wr_addr
  );

  modport slave (
    output start, rd_valid, pause, gs_valid, gs_done,
    input  busy, done, err, gs_enable, rd_en, rd_addr, wr_en, wr_addr
  );
endinterface

// File: rtl/gs_pipeline_ctrl.sv
// Sequences one grayscale frame pass: RWM_1 reads -> Grayscaler -> RWM_2 writes.
// Optional watchdog (ERR state, err output) is enabled by defining GSC_TIMEOUT_EN.
module gs_pipeline_ctrl #(
  parameter int N       = 2,
  parameter int M       = 2,
  parameter int AW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  gs_pipeline_ctrl_if.master  bus
);

  localparam logic [AW-1:0] RD_LAST = AW'(3 * N * M - 1);
  localparam logic [AW-1:0] PIX     = AW'(N * M);

  if ((3 * N * M > 2 ** AW) || (TIMEOUT < 1)) begin : g_bad_cfg
    $error("gs_pipeline_ctrl: illegal N/M/AW/TIMEOUT combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_STALL,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  logic          gs_seen;
  logic          rd_acc;
  logic          rd_last;
  logic          wr_issue;
  logic          frame_done;
  logic [AW-1:0] wr_cnt;

`ifdef GSC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic            err_q;
  logic [WD_W-1:0] wd_cnt;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // wr_cnt counts the write in flight, so the cap and the completion test
  // see a write the cycle it is strobed (gives last write -> done = 1 cycle).
  always_comb begin
    rd_acc     = (state == S_FETCH) && bus.rd_valid;
    rd_last    = rd_acc && (bus.rd_addr == RD_LAST);
    wr_cnt     = bus.wr_addr + AW'(bus.wr_en);
    wr_issue   = bus.busy && bus.gs_valid && (wr_cnt < PIX);
    frame_done = (gs_seen || bus.gs_done) && (wr_cnt == PIX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.gs_enable <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      gs_seen       <= 1'b0;
`ifdef GSC_TIMEOUT_EN
      err_q         <= 1'b0;
      wd_cnt        <= '0;
`endif
    end else begin
      bus.done  <= 1'b0;
      bus.wr_en <= wr_issue;
      if (bus.wr_en) bus.wr_addr <= bus.wr_addr + AW'(1);
      if (rd_acc)    bus.rd_addr <= bus.rd_addr + AW'(1);
      if (bus.busy && bus.gs_done) gs_seen <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            state         <= S_FETCH;
            bus.busy      <= 1'b1;
            bus.gs_enable <= 1'b1;
            bus.rd_en     <= 1'b1;
            bus.rd_addr   <= '0;
            bus.wr_en     <= 1'b0;
            bus.wr_addr   <= '0;
            gs_seen       <= 1'b0;
`ifdef GSC_TIMEOUT_EN
            err_q         <= 1'b0;
            wd_cnt        <= '0;
`endif
          end
        end
        S_FETCH: begin
          // last-byte accept wins over a coincident pause
          if (rd_last) begin
            state     <= S_DRAIN;
            bus.rd_en <= 1'b0;
          end else if (bus.pause) begin
            state     <= S_STALL;
            bus.rd_en <= 1'b0;
          end
        end
        S_STALL: begin
          state     <= S_FETCH;
          bus.rd_en <= 1'b1;
        end
        S_DRAIN: begin
          if (frame_done) begin
            state         <= S_DONE;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            bus.gs_enable <= 1'b0;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

`ifdef GSC_TIMEOUT_EN
      // Watchdog: a completing frame is never turned into an error.
      if (bus.busy) begin
        if (bus.rd_valid || bus.gs_valid || bus.gs_done) begin
          wd_cnt <= '0;
        end else if (wd_cnt == WD_W'(TIMEOUT - 1) && !(state == S_DRAIN && frame_done)) begin
          state         <= S_ERR;
          err_q         <= 1'b1;
          bus.busy      <= 1'b0;
          bus.gs_enable <= 1'b0;
          bus.rd_en     <= 1'b0;
          bus.wr_en     <= 1'b0;
        end else begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_gs_pipeline_ctrl.sv
// Randomized bench for gs_pipeline_ctrl against a counter-based frame model.
module tb_gs_pipeline_ctrl;
  localparam int N  = 2;
  localparam int M  = 2;
  localparam int AW = 8;
`ifdef GSC_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 64;
`endif
  localparam int NPIX  = N * M;
  localparam int NBYTE = 3 * N * M;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  gs_pipeline_ctrl_if #(.AW(AW)) bus ();

  gs_pipeline_ctrl #(.N(N), .M(M), .AW(AW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // model: what the outputs must be in the current cycle
  bit m_busy, m_rd_en, m_done, m_err, m_cool, m_seen, m_wr_en;
  int m_reads, m_wiss, m_idle;
  // Grayscaler / source stimulus bookkeeping
  int gv_sent;
  bit gd_sent;
  int done_seen;
  // knobs
  int k_rdv, k_pause, k_gs;
  bit k_spur, k_extra, k_early, k_withhold, k_pfix;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_busy = 0; m_rd_en = 0; m_done = 0; m_err = 0; m_cool = 0; m_seen = 0; m_wr_en = 0;
    m_reads = 0; m_wiss = 0; m_idle = 0; gv_sent = 0; gd_sent = 0;
  endtask

  task automatic drive_idle();
    bus.start = 0; bus.rd_valid = 0; bus.pause = 0; bus.gs_valid = 0; bus.gs_done = 0;
  endtask

  task automatic check_outputs();
    chk("busy",      bus.busy,      m_busy);
    chk("gs_enable", bus.gs_enable, m_busy);
    chk("rd_en",     bus.rd_en,     m_rd_en);
    chk("rd_addr",   bus.rd_addr,   m_reads);
    chk("wr_en",     bus.wr_en,     m_wr_en);
    chk("wr_addr",   bus.wr_addr,   m_wiss - int'(m_wr_en));
    chk("done",      bus.done,      m_done);
    chk("err",       bus.err,       m_err);
    if (bus.done === 1'b1) done_seen++;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step(input bit st_req);
    bit st, rv, pz, gv, gd, acc, nw, fin, erred, n_rd_en;
    int avail;
    check_outputs();

    st = st_req || (k_spur && m_busy && $urandom_range(0, 99) < 15);
    rv = $urandom_range(0, 99) < k_rdv;
    if (k_withhold) rv = rv && m_rd_en;
    if (k_pfix) pz = m_rd_en && rv && (m_reads % 3 == 2) && (m_reads < NBYTE - 1);
    else        pz = $urandom_range(0, 99) < k_pause;
    avail = m_reads / 3 - gv_sent;
    gv = m_busy && (avail > 0 || (k_extra && gv_sent >= NPIX)) && ($urandom_range(0, 99) < k_gs);
    if (k_extra && !m_busy && $urandom_range(0, 99) < 20) gv = 1;
    if (k_withhold && gv_sent >= 2) gv = 0;
    gd = 0;
    if (m_busy && !k_withhold && !gd_sent) begin
      if (k_early) gd = (m_reads >= 6) && m_rd_en;
      else         gd = (gv_sent >= NPIX) && ($urandom_range(0, 99) < 50);
    end

    bus.start = st; bus.rd_valid = rv; bus.pause = pz; bus.gs_valid = gv; bus.gs_done = gd;
    if (gv) gv_sent++;
    if (gd) gd_sent = 1;

    acc = m_rd_en && rv;
    nw  = m_busy && gv && (m_wiss < NPIX);
    fin = 0; erred = 0; n_rd_en = 0;
    if (m_busy) begin
      if (m_reads < NBYTE) n_rd_en = m_rd_en ? !((acc && m_reads == NBYTE - 1) || pz) : 1'b1;
      else                 fin = (m_seen || gd) && (m_wiss == NPIX);
`ifdef GSC_TIMEOUT_EN
      m_idle = (rv || gv || gd) ? 0 : m_idle + 1;
      erred  = (m_idle >= TO) && !fin;
`endif
      m_seen = m_seen || gd;
    end
    m_reads += int'(acc);
    m_wiss  += int'(nw);
    m_wr_en  = nw;
    m_done   = fin;
    if (fin) begin
      m_busy = 0; m_rd_en = 0; m_cool = 1;
    end else if (erred) begin
      m_busy = 0; m_rd_en = 0; m_wr_en = 0; m_err = 1; m_cool = 1;
    end else if (m_busy) begin
      m_rd_en = n_rd_en;
    end else if (m_cool) begin
      m_cool = 0;
    end else if (st) begin
      m_busy = 1; m_rd_en = 1; m_err = 0; m_reads = 0; m_wiss = 0; m_wr_en = 0;
      m_seen = 0; m_idle = 0; gv_sent = 0; gd_sent = 0;
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_pass(input bit start_in_done, input int exp_done);
    int budget;
    done_seen = 0;
    step(1'b1);
    budget = 2000;
    while (!m_cool && budget > 0) begin
      step(1'b0);
      budget--;
    end
    chk("pass_bounded", budget > 0, 1);
    step(start_in_done);
    repeat (3) step(1'b0);
    chk("done_count", done_seen, exp_done);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    drive_idle();
    model_zero();
    #1 check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_knobs(input int rdv, input int pause, input int gs,
                           input bit spur, input bit extra, input bit early,
                           input bit withhold, input bit pfix);
    k_rdv = rdv; k_pause = pause; k_gs = gs; k_spur = spur; k_extra = extra;
    k_early = early; k_withhold = withhold; k_pfix = pfix;
  endtask

  initial begin
    int guard;
    drive_idle();
    model_zero();
    set_knobs(100, 0, 100, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    step(1'b0);

    // nominal 2x2
    run_pass(1'b0, 1);
    // fixed pauses after bytes 3, 6, 9
    set_knobs(100, 0, 100, 0, 0, 0, 0, 1);
    run_pass(1'b0, 1);
    // starts while busy and in the DONE cycle
    set_knobs(80, 10, 70, 1, 0, 0, 0, 0);
    run_pass(1'b1, 1);
    // early gs_done during FETCH
    set_knobs(100, 0, 60, 0, 0, 1, 0, 0);
    run_pass(1'b0, 1);
    // extra gs_valid beyond the frame
    set_knobs(100, 0, 100, 0, 1, 0, 0, 0);
    run_pass(1'b0, 1);

    // reset after 5 reads, then a clean replay
    set_knobs(100, 0, 100, 0, 0, 0, 0, 0);
    step(1'b1);
    guard = 100;
    while (m_reads < 5 && guard > 0) begin
      step(1'b0);
      guard--;
    end
    chk("reads_before_reset", m_reads, 5);
    do_reset();
    step(1'b0);
    run_pass(1'b0, 1);

`ifdef GSC_TIMEOUT_EN
    set_knobs(100, 0, 100, 0, 0, 0, 1, 0);
    run_pass(1'b0, 0);
    chk("err_after_timeout", bus.err, 1);
    set_knobs(100, 0, 100, 0, 0, 0, 0, 0);
    run_pass(1'b0, 1);
`endif

    for (int i = 0; i < 8; i++) begin
      set_knobs($urandom_range(40, 100), $urandom_range(0, 40), $urandom_range(30, 100),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'b0, 1'b0);
      run_pass(1'($urandom_range(0, 1)), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
